// File: rtl/board_2x2.sv
// Two-tile rectangle renderer: a 2-stage pixel pipeline where each stage paints its tile colour over hits.
// Optional BOARD_2X2_ALPHA_EN makes a tile with zero alpha (TC[31:24]) transparent.
module board_2x2 #(
  parameter int SCREEN_W = 1080,
  parameter int SCREEN_H = 2160
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          program_in,
  input  logic [$clog2(SCREEN_W)-1:0]   x,
  input  logic [$clog2(SCREEN_H)-1:0]   y,
  input  logic [31:0]                   data_in,
  output logic [$clog2(SCREEN_W)-1:0]   x_out,
  output logic [$clog2(SCREEN_H)-1:0]   y_out,
  output logic [31:0]                   data_out
);

  localparam int XW = $clog2(SCREEN_W);
  localparam int YW = $clog2(SCREEN_H);

  logic [XW:0]   tx_r [2];
  logic [YW:0]   ty_r [2];
  logic [XW:0]   tw_r [2];
  logic [YW:0]   th_r [2];
  logic [31:0]   tc_r [2];

  logic [XW-1:0] x0_r;
  logic [YW-1:0] y0_r;
  logic [31:0]   c0_r;
  logic [31:0]   c0_next_s;
  logic [31:0]   c1_next_s;

  // Bounds sums are one bit wider than the operands so a tile reaching past the screen never wraps.
  function automatic logic tile_hit(input logic [XW-1:0] px, input logic [YW-1:0] py,
                                    input logic [XW:0] tx, input logic [YW:0] ty,
                                    input logic [XW:0] tw, input logic [YW:0] th);
    logic [XW+1:0] x_end;
    logic [YW+1:0] y_end;
    x_end = {1'b0, tx} + {1'b0, tw};
    y_end = {1'b0, ty} + {1'b0, th};
    return ({1'b0, px} >= tx) && ({2'b00, px} < x_end) &&
           ({1'b0, py} >= ty) && ({2'b00, py} < y_end);
  endfunction

  function automatic logic [31:0] shade(input logic hit, input logic [31:0] tc, input logic [31:0] c);
`ifdef BOARD_2X2_ALPHA_EN
    return (hit && (tc[31:24] != 8'd0)) ? tc : c;
`else
    return hit ? tc : c;
`endif
  endfunction

  // Tile register file; writes to tiles above 1 or addresses above 4 are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        tx_r[i] <= '0;
        ty_r[i] <= '0;
        tw_r[i] <= '0;
        th_r[i] <= '0;
        tc_r[i] <= '0;
      end
    end else if (program_in && (x[XW-1:1] == '0)) begin
      case (y)
        YW'(0):  tx_r[x[0]] <= data_in[XW:0];
        YW'(1):  ty_r[x[0]] <= data_in[YW:0];
        YW'(2):  tw_r[x[0]] <= data_in[XW:0];
        YW'(3):  th_r[x[0]] <= data_in[YW:0];
        YW'(4):  tc_r[x[0]] <= data_in;
        default: ;
      endcase
    end else begin
      // render cycle: tile registers hold
    end
  end

  // Per-stage colour selection.
  always_comb begin
    c0_next_s = shade(tile_hit(x, y, tx_r[0], ty_r[0], tw_r[0], th_r[0]), tc_r[0], data_in);
    c1_next_s = shade(tile_hit(x0_r, y0_r, tx_r[1], ty_r[1], tw_r[1], th_r[1]), tc_r[1], c0_r);
  end

  // Two pipeline stages; they advance every cycle, programming cycles included.
  always_ff @(posedge clk) begin
    if (rst) begin
      x0_r     <= '0;
      y0_r     <= '0;
      c0_r     <= '0;
      x_out    <= '0;
      y_out    <= '0;
      data_out <= '0;
    end else begin
      x0_r     <= x;
      y0_r     <= y;
      c0_r     <= c0_next_s;
      x_out    <= x0_r;
      y_out    <= y0_r;
      data_out <= c1_next_s;
    end
  end

endmodule

// File: tb/tb_board_2x2.sv
// Scoreboard bench for board_2x2: the driver queues hand-computed pixels, a monitor checks them 2 cycles later.
module tb_board_2x2;

  typedef struct packed {
    logic [10:0] px;
    logic [11:0] py;
    logic [31:0] col;
  } pix_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        program_in = 1'b0;
  logic [10:0] x = 11'd0;
  logic [11:0] y = 12'd0;
  logic [31:0] data_in = 32'd0;
  logic [10:0] x_out;
  logic [11:0] y_out;
  logic [31:0] data_out;

  logic chk_in = 1'b0;
  logic d1 = 1'b0;
  logic d2 = 1'b0;
  logic rchk = 1'b0;
  pix_t sb[$];
  pix_t e;
  int compared = 0;
  int mismatched = 0;

  localparam logic [31:0] BG = 32'hFF000000;
  localparam logic [31:0] WH = 32'hFFFFFFFF;

  board_2x2 #(.SCREEN_W(1080), .SCREEN_H(2160)) dut (
    .clk(clk), .rst(rst), .program_in(program_in), .x(x), .y(y), .data_in(data_in),
    .x_out(x_out), .y_out(y_out), .data_out(data_out)
  );

  always #5 clk = ~clk;

  // Delay the "check this pixel" tag by the pipeline depth; reset kills tags in flight.
  always @(posedge clk) begin
    if (rst) begin
      d1 <= 1'b0;
      d2 <= 1'b0;
    end else begin
      d1 <= chk_in;
      d2 <= d1;
    end
    rchk <= rst;
  end

  // Monitor: compare outputs shortly after each rising edge.
  always @(posedge clk) begin
    #1;
    if (rchk) begin
      compared++;
      if (x_out !== 11'd0 || y_out !== 12'd0 || data_out !== 32'd0) begin
        mismatched++;
        $display("FAIL reset_zero: got x=%0d y=%0d c=%08h, want 0 0 00000000", x_out, y_out, data_out);
      end
    end
    if (d2) begin
      compared++;
      if (sb.size() == 0) begin
        mismatched++;
        $display("FAIL sb_underflow: got output x=%0d y=%0d c=%08h, want no output", x_out, y_out, data_out);
      end else begin
        e = sb.pop_front();
        if (x_out !== e.px || y_out !== e.py || data_out !== e.col) begin
          mismatched++;
          $display("FAIL pixel(%0d,%0d): got x=%0d y=%0d c=%08h, want x=%0d y=%0d c=%08h",
                   e.px, e.py, x_out, y_out, data_out, e.px, e.py, e.col);
        end
      end
    end
  end

  task automatic pix(input logic [10:0] px, input logic [11:0] py, input logic [31:0] bg,
                     input logic [31:0] want, input logic chk);
    @(negedge clk);
    rst = 1'b0; program_in = 1'b0; x = px; y = py; data_in = bg; chk_in = chk;
    if (chk) sb.push_back('{px, py, want});
  endtask

  task automatic wr(input logic [10:0] t, input logic [11:0] a, input logic [31:0] d);
    @(negedge clk);
    rst = 1'b0; program_in = 1'b1; x = t; y = a; data_in = d; chk_in = 1'b0;
  endtask

  task automatic tile(input logic [10:0] t, input logic [31:0] tx, input logic [31:0] ty,
                      input logic [31:0] tw, input logic [31:0] th, input logic [31:0] tc);
    wr(t, 12'd0, tx);
    wr(t, 12'd1, ty);
    wr(t, 12'd2, tw);
    wr(t, 12'd3, th);
    wr(t, 12'd4, tc);
  endtask

  task automatic do_rst();
    @(negedge clk);
    rst = 1'b1; program_in = 1'b0; chk_in = 1'b0;
  endtask

  initial begin
    do_rst();
    do_rst();
    // No tiles after reset: background passes.
    pix(11'd5, 12'd5, BG, BG, 1'b1);

    // Checkerboard.
    tile(11'd0, 32'd0, 32'd0, 32'd540, 32'd1080, WH);
    tile(11'd1, 32'd540, 32'd1080, 32'd540, 32'd1080, WH);
    pix(11'd0,    12'd0,    BG, WH, 1'b1);
    pix(11'd539,  12'd1079, BG, WH, 1'b1);
    pix(11'd540,  12'd0,    BG, BG, 1'b1);
    pix(11'd0,    12'd1080, BG, BG, 1'b1);
    pix(11'd540,  12'd1080, BG, WH, 1'b1);
    pix(11'd1079, 12'd2159, BG, WH, 1'b1);
    pix(11'd1079, 12'd1079, BG, BG, 1'b1);
    pix(11'd539,  12'd2159, BG, BG, 1'b1);

    // Ignored writes leave both tiles intact.
    wr(11'd2, 12'd0, 32'h12345678);
    wr(11'd3, 12'd4, 32'h12345678);
    wr(11'd0, 12'd7, 32'h12345678);
    wr(11'd1, 12'd7, 32'h12345678);
    pix(11'd0,   12'd0,    BG, WH, 1'b1);
    pix(11'd540, 12'd1080, BG, WH, 1'b1);
    pix(11'd600, 12'd100,  BG, BG, 1'b1);

    // Mid-stream reset: the pixel in flight is discarded and outputs read 0.
    pix(11'd1, 12'd1, BG, WH, 1'b1);
    pix(11'd2, 12'd2, BG, WH, 1'b0);
    do_rst();
    pix(11'd0,   12'd0,    BG, BG, 1'b1);
    pix(11'd600, 12'd1200, BG, BG, 1'b1);

    // Boundaries of tile 0 = (100,200,10,20).
    tile(11'd0, 32'd100, 32'd200, 32'd10, 32'd20, 32'hAABBCCDD);
    pix(11'd109, 12'd219, 32'h12345678, 32'hAABBCCDD, 1'b1);
    pix(11'd100, 12'd200, 32'h12345678, 32'hAABBCCDD, 1'b1);
    pix(11'd110, 12'd200, 32'h12345678, 32'h12345678, 1'b1);
    pix(11'd100, 12'd220, 32'h12345678, 32'h12345678, 1'b1);
    pix(11'd99,  12'd200, 32'h12345678, 32'h12345678, 1'b1);
    pix(11'd109, 12'd199, 32'h12345678, 32'h12345678, 1'b1);

    // Wide tile whose right edge is beyond 12 bits: must not wrap.
    tile(11'd0, 32'd1000, 32'd0, 32'd4000, 32'd100, 32'h0BADF00D);
    pix(11'd2000, 12'd50, BG, 32'h0BADF00D, 1'b1);
    pix(11'd999,  12'd50, BG, BG, 1'b1);

    // Overlap: tile 1 wins.
    tile(11'd0, 32'd0, 32'd0, 32'd8, 32'd8, 32'h11111111);
    tile(11'd1, 32'd0, 32'd0, 32'd8, 32'd8, 32'h22222222);
    pix(11'd3, 12'd3, BG, 32'h22222222, 1'b1);
    pix(11'd7, 12'd7, BG, 32'h22222222, 1'b1);
    pix(11'd8, 12'd3, BG, BG, 1'b1);

    // Tile 1 disabled (TW=0) exposes tile 0, then zero-alpha colour on tile 0.
    wr(11'd1, 12'd2, 32'd0);
    pix(11'd3, 12'd3, BG, 32'h11111111, 1'b1);
    wr(11'd0, 12'd4, 32'h00FFFFFF);
`ifdef BOARD_2X2_ALPHA_EN
    pix(11'd2, 12'd2, BG, BG, 1'b1);
`else
    pix(11'd2, 12'd2, BG, 32'h00FFFFFF, 1'b1);
`endif

    // Drain.
    pix(11'd0, 12'd0, BG, BG, 1'b0);
    pix(11'd0, 12'd0, BG, BG, 1'b0);
    pix(11'd0, 12'd0, BG, BG, 1'b0);
    @(negedge clk);
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL sb_drain: got %0d pending, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
